add_sub_pipe: RTL and testbench
===============================

ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width in bits; legal values are multiples of 4*PIPE_STAGES, range 8..64.
REQ-002 SHALL have parameter PIPE_STAGES, default 2, number of carry-chain pipeline stages; legal values are 1..4.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-007 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid && in_ready.
REQ-008 SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-009 SHALL have ports A and B, input, DATA_WIDTH bits each: signed two's-complement operands.
REQ-010 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready.
REQ-012 SHALL have port result, output, DATA_WIDTH bits: sum/difference.
REQ-013 SHALL have port carry_out, output, 1 bit: unsigned carry; for subtract, 1 = no borrow.
REQ-014 SHALL have port overflow, output, 1 bit: signed overflow of this beat.
REQ-015 SHALL have port ovf_sticky, output, 1 bit: set by any delivered overflow beat.
REQ-016 SHALL have port ovf_clr, input, 1 bit: clears ovf_sticky.

Function
REQ-017 SHALL compute subtraction as A + ~B + 1; the carry-in is op.
REQ-018 SHALL split the carry chain into PIPE_STAGES slices of DATA_WIDTH/PIPE_STAGES bits, each built from 4-bit carry-lookahead groups with ripple between groups.
REQ-019 SHALL register the carry and the partial result between slices; the unprocessed upper operand bits ride along in the same registers.
REQ-020 SHALL have a latency of exactly PIPE_STAGES cycles from the accept edge to out_valid, when not stalled.
REQ-021 SHALL sustain one beat per cycle when out_ready is held high.
REQ-022 SHALL stall globally: advance = !out_valid || out_ready; all stages hold when advance = 0.
REQ-023 SHALL drive in_ready = advance combinationally; bubbles do not collapse.
REQ-024 SHALL hold result, carry_out and overflow stable while out_valid && !out_ready.
REQ-025 SHALL deliver beats in acceptance order, with no loss or duplication.
REQ-026 SHALL compute overflow as (sign of A == sign of effective B) && (sign of result != sign of A), where effective B = B for add and ~B for subtract.
REQ-027 SHALL set ovf_sticky on the handshake edge of an overflow beat.
REQ-028 SHALL give ovf_clr priority when ovf_clr coincides with a set; ovf_sticky reads 0 on the next cycle.
REQ-029 SHALL ignore A, B and op when in_valid is 0.

Reset
REQ-030 SHALL, while rst_n = 0 at a clock edge, clear all stage valid bits, out_valid, result, carry_out, overflow and ovf_sticky to 0.
REQ-031 SHALL discard in-flight beats on reset mid-operation; none are delivered after rst_n returns to 1.
REQ-032 SHALL drive in_ready = 1 during and immediately after reset, since the pipeline is empty.

Configuration
REQ-033 SHALL, with macro ADD_SUB_SAT_EN defined, saturate result on overflow: positive overflow gives 0x7FF..F, negative overflow gives 0x800..0; overflow and carry_out are still reported.
REQ-034 SHALL, with ADD_SUB_SAT_EN undefined, output the wrapped two's-complement result and omit the saturation logic.

Verification (DATA_WIDTH=16, PIPE_STAGES=2)
REQ-035 SHALL cover: add 0x7FFF+0x0001 -> result 0x8000 (0x7FFF with SAT), overflow=1, carry_out=0, ovf_sticky=1, out_valid 2 cycles after accept.
REQ-036 SHALL cover: sub 0x8000-0x0001 -> result 0x7FFF (0x8000 with SAT), overflow=1, carry_out=1.
REQ-037 SHALL cover: sub 0x1234-0x1234 -> 0x0000, carry_out=1, overflow=0; add 0x00FF+0x0F01 -> 0x1000, exercising the inter-group and inter-stage carry.
REQ-038 SHALL cover: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 2, in order.
REQ-039 SHALL cover: out_ready=0 for 3 cycles with 2 beats in flight -> in_ready=0, output held stable, both beats later delivered in order.
REQ-040 SHALL cover: rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 and ovf_sticky=0 afterwards, no stale beat emerges, ovf_clr=1 clears ovf_sticky.

Source files
------------

// File: rtl/add_sub_pipe_if.sv
// Operand/result stream bundle for add_sub_pipe: operand beat in, result beat out,
// plus the sticky overflow flag and its clear.
interface add_sub_pipe_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         in_valid;
  logic                         in_ready;
  logic                         op;
  logic signed [DATA_WIDTH-1:0] A;
  logic signed [DATA_WIDTH-1:0] B;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] result;
  logic                         carry_out;
  logic                         overflow;
  logic                         ovf_sticky;
  logic                         ovf_clr;

  modport slave (
    input  in_valid, op, A, B, out_ready, ovf_clr,
    output in_ready, out_valid, result, carry_out, overflow, ovf_sticky
  );

  modport master (
    output in_valid, op, A, B, out_ready, ovf_clr,
    input  in_ready, out_valid, result, carry_out, overflow, ovf_sticky
  );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined signed add/subtract: carry chain split into PIPE_STAGES slices of 4-bit CLA groups.
// Define ADD_SUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module add_sub_pipe #(
  parameter int DATA_WIDTH  = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  add_sub_pipe_if.slave bus
);
  localparam int SW     = DATA_WIDTH / PIPE_STAGES;
  localparam int GROUPS = SW / 4;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

  function automatic logic [SW:0] slice_add(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                            input logic cin);
    logic [SW-1:0] s;
    logic          c;
    logic [4:0]    grp;
    s = '0;
    c = cin;
    for (int gi = 0; gi < GROUPS; gi++) begin
      grp           = cla4(a[gi*4 +: 4], b[gi*4 +: 4], c);
      s[gi*4 +: 4]  = grp[3:0];
      c             = grp[4];
    end
    return {c, s};
  endfunction

`ifdef ADD_SUB_SAT_EN
  function automatic logic [DATA_WIDTH-1:0] saturate(input logic [DATA_WIDTH-1:0] sum,
                                                     input logic ovf, input logic a_sign);
    if (!ovf)
      return sum;
    return a_sign ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction
`endif

  // x_p holds finished result bits below the current slice and untouched A bits above it
  logic                  vld_p [0:PIPE_STAGES];
  logic [DATA_WIDTH-1:0] x_p   [0:PIPE_STAGES-1];
  logic [DATA_WIDTH-1:0] b_p   [0:PIPE_STAGES-1];
  logic                  c_p   [0:PIPE_STAGES-1];
  logic [DATA_WIDTH-1:0] x_nx  [0:PIPE_STAGES-1];
  logic                  c_nx  [0:PIPE_STAGES-1];

  logic                  advance;
  logic                  a_sign;
  logic                  b_sign;
  logic                  ovf_nx;
  logic [DATA_WIDTH-1:0] sum_nx;
  logic [DATA_WIDTH-1:0] result_nx;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  carry_q;
  logic                  ovf_q;
  logic                  sticky_q;

  assign advance = !rst_n || !vld_p[PIPE_STAGES] || bus.out_ready;

  always_comb begin
    logic [SW:0] sl;
    sl = '0;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      sl                 = slice_add(x_p[k][k*SW +: SW], b_p[k][k*SW +: SW], c_p[k]);
      x_nx[k]            = x_p[k];
      x_nx[k][k*SW +: SW] = sl[SW-1:0];
      c_nx[k]            = sl[SW];
    end
  end

  assign a_sign = x_p[PIPE_STAGES-1][DATA_WIDTH-1];
  assign b_sign = b_p[PIPE_STAGES-1][DATA_WIDTH-1];
  assign sum_nx = x_nx[PIPE_STAGES-1];
  assign ovf_nx = (a_sign == b_sign) && (sum_nx[DATA_WIDTH-1] != a_sign);

`ifdef ADD_SUB_SAT_EN
  assign result_nx = saturate(sum_nx, ovf_nx, a_sign);
`else
  assign result_nx = sum_nx;
`endif

  // Stage p0 captures operands; stages p1..pN-1 each resolve one slice
  always_ff @(posedge clk) begin
    if (advance && bus.in_valid) begin
      x_p[0] <= bus.A;
      b_p[0] <= bus.op ? ~bus.B : bus.B;
      c_p[0] <= bus.op;
    end
    for (int k = 1; k < PIPE_STAGES; k++) begin
      if (advance && vld_p[k-1]) begin
        x_p[k] <= x_nx[k-1];
        b_p[k] <= b_p[k-1];
        c_p[k] <= c_nx[k-1];
      end
    end
  end

  // Output stage: last slice resolved, overflow evaluated, sticky flag maintained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= PIPE_STAGES; k++)
        vld_p[k] <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (advance) begin
        vld_p[0] <= bus.in_valid;
        for (int k = 1; k <= PIPE_STAGES; k++)
          vld_p[k] <= vld_p[k-1];
        if (vld_p[PIPE_STAGES-1]) begin
          result_q <= result_nx;
          carry_q  <= c_nx[PIPE_STAGES-1];
          ovf_q    <= ovf_nx;
        end
      end
      if (bus.ovf_clr)
        sticky_q <= 1'b0;
      else if (vld_p[PIPE_STAGES] && bus.out_ready && ovf_q)
        sticky_q <= 1'b1;
    end
  end

  assign bus.in_ready   = advance;
  assign bus.out_valid  = vld_p[PIPE_STAGES];
  assign bus.result     = result_q;
  assign bus.carry_out  = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.ovf_sticky = sticky_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed bench for add_sub_pipe (DATA_WIDTH=16, PIPE_STAGES=2); honours ADD_SUB_SAT_EN.
module tb_add_sub_pipe;
  localparam int W = 16;

`ifdef ADD_SUB_SAT_EN
  localparam logic [15:0] E_7FFF_P1 = 16'h7FFF;
  localparam logic [15:0] E_8000_M1 = 16'h8000;
  localparam logic [15:0] E_7FFF_PP = 16'h7FFF;
  localparam logic [15:0] E_8000_NN = 16'h8000;
`else
  localparam logic [15:0] E_7FFF_P1 = 16'h8000;
  localparam logic [15:0] E_8000_M1 = 16'h7FFF;
  localparam logic [15:0] E_7FFF_PP = 16'hFFFE;
  localparam logic [15:0] E_8000_NN = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  add_sub_pipe_if #(.DATA_WIDTH(W)) bus ();

  add_sub_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic        tv_op [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] tv_a  [8] = '{16'h0001, 16'h1000, 16'h00F0, 16'hFFFF, 16'h0005, 16'h4000, 16'hC000, 16'h0F0F};
  logic [15:0] tv_b  [8] = '{16'h0002, 16'h0001, 16'h0010, 16'h0001, 16'h0007, 16'h3FFF, 16'hC000, 16'h0F0F};
  logic [15:0] tv_r  [8] = '{16'h0003, 16'h0FFF, 16'h0100, 16'h0000, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000};
  logic        tv_c  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic o, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.A        = a;
    bus.B        = b;
  endtask

  task automatic run_one(input logic o, input logic [15:0] a, input logic [15:0] b);
    drive(o, a, b);
    tick();
    bus.in_valid = 1'b0;
    bus.A        = 16'hDEAD;
    bus.B        = 16'hBEEF;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;
    bus.ovf_clr   = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 16'(bus.in_ready), 16'h1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_carry", 16'(bus.carry_out), 16'h0);
    chk("rst_overflow", 16'(bus.overflow), 16'h0);
    chk("rst_sticky", 16'(bus.ovf_sticky), 16'h0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 16'(bus.in_ready), 16'h1);

    // 0x7FFF + 1 with latency check
    drive(1'b0, 16'h7FFF, 16'h0001);
    tick();
    bus.in_valid = 1'b0;
    bus.A        = 16'hDEAD;
    chk("lat1_valid", 16'(bus.out_valid), 16'h0);
    tick();
    chk("lat1b_valid", 16'(bus.out_valid), 16'h0);
    tick();
    chk("lat2_valid", 16'(bus.out_valid), 16'h1);
    chk("add_ovf_result", bus.result, E_7FFF_P1);
    chk("add_ovf_flag", 16'(bus.overflow), 16'h1);
    chk("add_ovf_carry", 16'(bus.carry_out), 16'h0);
    chk("add_ovf_sticky_pre", 16'(bus.ovf_sticky), 16'h0);
    tick();
    chk("add_ovf_sticky", 16'(bus.ovf_sticky), 16'h1);
    chk("add_ovf_drained", 16'(bus.out_valid), 16'h0);

    run_one(1'b1, 16'h8000, 16'h0001);
    chk("sub_ovf_result", bus.result, E_8000_M1);
    chk("sub_ovf_flag", 16'(bus.overflow), 16'h1);
    chk("sub_ovf_carry", 16'(bus.carry_out), 16'h1);
    tick();

    run_one(1'b1, 16'h1234, 16'h1234);
    chk("sub_eq_result", bus.result, 16'h0000);
    chk("sub_eq_carry", 16'(bus.carry_out), 16'h1);
    chk("sub_eq_ovf", 16'(bus.overflow), 16'h0);
    tick();

    run_one(1'b0, 16'h00FF, 16'h0F01);
    chk("add_chain_result", bus.result, 16'h1000);
    chk("add_chain_carry", 16'(bus.carry_out), 16'h0);
    chk("add_chain_ovf", 16'(bus.overflow), 16'h0);
    tick();

    // Eight back-to-back beats
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 8)
        drive(tv_op[cyc], tv_a[cyc], tv_b[cyc]);
      else
        bus.in_valid = 1'b0;
      tick();
      chk("b2b_in_ready", 16'(bus.in_ready), 16'h1);
      if (cyc >= 2) begin
        chk("b2b_valid", 16'(bus.out_valid), 16'h1);
        chk("b2b_result", bus.result, tv_r[cyc-2]);
        chk("b2b_carry", 16'(bus.carry_out), 16'(tv_c[cyc-2]));
      end else begin
        chk("b2b_lead_valid", 16'(bus.out_valid), 16'h0);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b_tail_valid", 16'(bus.out_valid), 16'h0);

    // Backpressure with two beats in flight
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0010, 16'h0020);
    tick();
    drive(1'b1, 16'h0100, 16'h0001);
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 16'(bus.out_valid), 16'h1);
      chk("stall_in_ready", 16'(bus.in_ready), 16'h0);
      chk("stall_result", bus.result, 16'h0030);
      chk("stall_carry", 16'(bus.carry_out), 16'h0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("release_valid", 16'(bus.out_valid), 16'h1);
    chk("release_result", bus.result, 16'h00FF);
    chk("release_carry", 16'(bus.carry_out), 16'h1);
    tick();
    chk("release_drained", 16'(bus.out_valid), 16'h0);

    // Reset with two overflow beats in flight
    chk("pre_rst_sticky", 16'(bus.ovf_sticky), 16'h1);
    drive(1'b0, 16'h7FFF, 16'h7FFF);
    tick();
    drive(1'b0, 16'h7FFF, 16'h7FFF);
    tick();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    chk("mid_rst_in_ready", 16'(bus.in_ready), 16'h1);
    tick();
    chk("mid_rst_valid", 16'(bus.out_valid), 16'h0);
    chk("mid_rst_sticky", 16'(bus.ovf_sticky), 16'h0);
    chk("mid_rst_result", bus.result, 16'h0000);
    rst_n = 1'b1;
    #1;
    chk("after_rst_in_ready", 16'(bus.in_ready), 16'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_stale_valid", 16'(bus.out_valid), 16'h0);
      chk("no_stale_sticky", 16'(bus.ovf_sticky), 16'h0);
    end

    // Clear coinciding with an overflow handshake wins
    run_one(1'b0, 16'h7FFF, 16'h7FFF);
    chk("pp_result", bus.result, E_7FFF_PP);
    chk("pp_ovf", 16'(bus.overflow), 16'h1);
    chk("pp_carry", 16'(bus.carry_out), 16'h0);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("clr_priority_sticky", 16'(bus.ovf_sticky), 16'h0);

    run_one(1'b0, 16'h8000, 16'h8000);
    chk("nn_result", bus.result, E_8000_NN);
    chk("nn_ovf", 16'(bus.overflow), 16'h1);
    chk("nn_carry", 16'(bus.carry_out), 16'h1);
    tick();
    chk("nn_sticky_set", 16'(bus.ovf_sticky), 16'h1);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("clr_sticky", 16'(bus.ovf_sticky), 16'h0);
    tick();
    chk("clr_sticky_hold", 16'(bus.ovf_sticky), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
